// File: rtl/mod_ctrl_pkg.sv
// Shared types and helpers for the modulus counter sequencer: FSM state,
// segment command record and the direction-dependent start/terminal values.
package mod_ctrl_pkg;

    localparam int CTRL_WIDTH = 3;
    localparam int CTRL_REP_W = 4;

    localparam logic [CTRL_WIDTH-1:0] MIN_MOD = CTRL_WIDTH'(2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [CTRL_WIDTH-1:0] mod;
        logic                  updown;
        logic [CTRL_REP_W-1:0] rep;
    } cmd_t;

    function automatic logic [CTRL_WIDTH-1:0] start_value(
        input logic [CTRL_WIDTH-1:0] mod,
        input logic                  updown
    );
        return updown ? '0 : mod - CTRL_WIDTH'(1);
    endfunction

    function automatic logic [CTRL_WIDTH-1:0] term_value(
        input logic [CTRL_WIDTH-1:0] mod,
        input logic                  updown
    );
        return updown ? mod - CTRL_WIDTH'(1) : '0;
    endfunction

endpackage

// File: rtl/mod_counter_core.sv
// Modulus up/down counter register: load forces the start value, en steps
// the count and wraps it back to the start value at the terminal value.
module mod_counter_core
    import mod_ctrl_pkg::*;
#(
    parameter int WIDTH = CTRL_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] mod,
    input  logic             updown,
    output logic [WIDTH-1:0] count,
    output logic             term
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_start;
    logic [WIDTH-1:0] w_step;

    assign w_start = start_value(mod, updown);
    assign w_step  = updown ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
    assign term    = (r_count == term_value(mod, updown));
    assign count   = r_count;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= w_start;
        end else if (en) begin
            r_count <= term ? w_start : w_step;
        end
    end

endmodule

// File: rtl/mod_count_ctrl.sv
// Command-driven sequencer for the modulus counter. Define MODCTRL_QUEUE_EN
// to add a DEPTH-entry command FIFO; without it commands are taken only in IDLE.
module mod_count_ctrl
    import mod_ctrl_pkg::*;
#(
    parameter int WIDTH = CTRL_WIDTH,
    parameter int REP_W = CTRL_REP_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_mod,
    input  logic             cmd_updown,
    input  logic [REP_W-1:0] cmd_rep,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             active,
    output logic             wrap,
    output logic             seg_done,
    output logic             cmd_err
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("mod_count_ctrl: DEPTH must be a power of two >= 2");
    end

    state_t     r_state;
    state_t     w_next_state;
    cmd_t       r_cur;
    cmd_t       w_cmd_in;
    cmd_t       w_q_head;
    logic [REP_W-1:0] r_rep_left;
    logic       r_cmd_err;
    logic       w_accept;
    logic       w_mod_ok;
    logic       w_q_nonempty;
    logic       w_pop;
    logic       w_bypass;
    logic       w_term;
    logic       w_last;
    logic       w_load;
    logic       w_en;

    assign w_accept = cmd_valid && cmd_ready;
    assign w_mod_ok = (cmd_mod >= MIN_MOD);
    assign w_cmd_in = '{mod: cmd_mod, updown: cmd_updown, rep: cmd_rep};

    // A queued command always wins over the bus so segments run in arrival order.
    assign w_pop    = !abort && w_q_nonempty && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_bypass = !abort && (r_state == ST_IDLE) && !w_q_nonempty && w_accept && w_mod_ok;

    assign w_last = w_term && (r_rep_left == '0);
    assign w_load = (r_state == ST_LOAD) && !abort;
    assign w_en   = (r_state == ST_RUN) && !abort && !w_last;

`ifdef MODCTRL_QUEUE_EN
    localparam int PTR_W = $clog2(DEPTH);

    cmd_t             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_fill;
    logic             w_full;
    logic             w_push;

    assign w_full       = (r_fill == (PTR_W+1)'(DEPTH));
    assign w_q_nonempty = (r_fill != '0);
    assign w_q_head     = r_mem[r_rd_ptr];
    assign w_push       = w_accept && w_mod_ok && !w_bypass;
    assign cmd_ready    = !rst && !w_full && !abort;

    // NOTE: FIFO storage has no reset; r_fill alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_cmd_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else if (abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + (PTR_W+1)'(1);
                2'b01:   r_fill <= r_fill - (PTR_W+1)'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end
`else
    assign w_q_nonempty = 1'b0;
    assign w_q_head     = '0;
    assign cmd_ready    = !rst && (r_state == ST_IDLE) && !abort;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        if (abort) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_pop || w_bypass) w_next_state = ST_LOAD;
                ST_LOAD: w_next_state = ST_RUN;
                ST_RUN:  if (w_last) w_next_state = ST_DONE;
                ST_DONE: w_next_state = w_pop ? ST_LOAD : ST_IDLE;
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        active   = 1'b0;
        wrap     = 1'b0;
        seg_done = 1'b0;
        case (r_state)
            ST_RUN: begin
                active = 1'b1;
                wrap   = w_term;
            end
            ST_DONE: seg_done = 1'b1;
            default: ;
        endcase
    end

    assign cmd_err = r_cmd_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur      <= '0;
            r_rep_left <= '0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_cmd_err <= w_accept && !w_mod_ok;
            if (w_pop) begin
                r_cur <= w_q_head;
            end else if (w_bypass) begin
                r_cur <= w_cmd_in;
            end
            if (w_load) begin
                r_rep_left <= r_cur.rep;
            end else if ((r_state == ST_RUN) && !abort && w_term && (r_rep_left != '0)) begin
                r_rep_left <= r_rep_left - REP_W'(1);
            end
        end
    end

    mod_counter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (w_load),
        .en     (w_en),
        .mod    (r_cur.mod),
        .updown (r_cur.updown),
        .count  (count),
        .term   (w_term)
    );

endmodule

// File: tb/tb_mod_count_ctrl.sv
// Directed bench for mod_count_ctrl; the queue scenario is selected by
// MODCTRL_QUEUE_EN, matching the RTL build.
module tb_mod_count_ctrl;

    localparam int WIDTH = 3;
    localparam int REP_W = 4;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_mod;
    logic             cmd_updown;
    logic [REP_W-1:0] cmd_rep;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic             active;
    logic             wrap;
    logic             seg_done;
    logic             cmd_err;

    int n_checks = 0;
    int n_pass   = 0;
    int n_seg    = 0;
    int seg_base = 0;

    mod_count_ctrl #(
        .WIDTH(WIDTH),
        .REP_W(REP_W),
        .DEPTH(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mod    (cmd_mod),
        .cmd_updown (cmd_updown),
        .cmd_rep    (cmd_rep),
        .abort      (abort),
        .count      (count),
        .active     (active),
        .wrap       (wrap),
        .seg_done   (seg_done),
        .cmd_err    (cmd_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (seg_done === 1'b1) n_seg++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    endtask

    // Called at edge+1; returns at edge+1 after the accepting edge.
    task automatic send(input int m, input bit up, input int rep, input string tag);
        cmd_mod    = WIDTH'(m);
        cmd_updown = up;
        cmd_rep    = REP_W'(rep);
        cmd_valid  = 1'b1;
        #1 check({tag, " ready"}, 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Called during LOAD; checks every RUN cycle, the DONE cycle and the cycle after.
    task automatic expect_segment(input int m, input bit up, input int rep, input string name);
        int term_v;
        term_v = up ? m - 1 : 0;
        @(posedge clk); #1;
        for (int p = 0; p <= rep; p++) begin
            for (int i = 0; i < m; i++) begin
                int exp_c;
                exp_c = up ? i : m - 1 - i;
                check($sformatf("%s p%0d i%0d count", name, p, i), 32'(count), 32'(exp_c));
                check($sformatf("%s p%0d i%0d wrap", name, p, i), 32'(wrap), 32'(i == m - 1));
                check($sformatf("%s p%0d i%0d active", name, p, i), 32'(active), 32'd1);
                @(posedge clk); #1;
            end
        end
        check({name, " done seg_done"}, 32'(seg_done), 32'd1);
        check({name, " done active"}, 32'(active), 32'd0);
        check({name, " done count"}, 32'(count), 32'(term_v));
        @(posedge clk); #1;
        check({name, " after seg_done"}, 32'(seg_done), 32'd0);
        check({name, " after active"}, 32'(active), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_mod    = '0;
        cmd_updown = 1'b0;
        cmd_rep    = '0;
        abort      = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset count", 32'(count), 32'd0);
        check("reset active", 32'(active), 32'd0);
        check("reset wrap", 32'(wrap), 32'd0);
        check("reset seg_done", 32'(seg_done), 32'd0);
        check("reset cmd_err", 32'(cmd_err), 32'd0);
        check("reset cmd_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        #1 check("post-reset cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;

        // mod 5 up, single period
        send(5, 1'b1, 0, "up5");
        check("up5 load active", 32'(active), 32'd0);
        expect_segment(5, 1'b1, 0, "up5");
        @(posedge clk); #1;
        check("up5 idle count", 32'(count), 32'd4);
        check("up5 idle active", 32'(active), 32'd0);

        // rejected moduli
        send(1, 1'b1, 0, "err1");
        check("err1 cmd_err", 32'(cmd_err), 32'd1);
        check("err1 active", 32'(active), 32'd0);
        @(posedge clk); #1;
        check("err1 cmd_err clear", 32'(cmd_err), 32'd0);
        check("err1 active idle", 32'(active), 32'd0);
        check("err1 count", 32'(count), 32'd4);
        send(0, 1'b0, 3, "err0");
        check("err0 cmd_err", 32'(cmd_err), 32'd1);
        @(posedge clk); #1;
        check("err0 cmd_err clear", 32'(cmd_err), 32'd0);
        check("err0 active idle", 32'(active), 32'd0);
        check("err0 count", 32'(count), 32'd4);

        // mod 5 down, two periods
        seg_base = n_seg;
        send(5, 1'b0, 1, "dn5");
        expect_segment(5, 1'b0, 1, "dn5");
        check("dn5 seg_done pulses", 32'(n_seg - seg_base), 32'd1);

`ifdef MODCTRL_QUEUE_EN
        // First command bypasses the queue, the next four fill it.
        seg_base = n_seg;
        send(3, 1'b1, 0, "q A");
        fork
            begin
                send(5, 1'b0, 0, "q B");
                send(7, 1'b1, 0, "q C");
                send(2, 1'b0, 0, "q D");
                send(4, 1'b1, 0, "q E");
                cmd_mod    = WIDTH'(6);
                cmd_updown = 1'b1;
                cmd_rep    = '0;
                cmd_valid  = 1'b1;
                #1 check("q full ready", 32'(cmd_ready), 32'd0);
                @(posedge clk); #1;
                cmd_valid = 1'b0;
            end
            begin
                expect_segment(3, 1'b1, 0, "qA");
                expect_segment(5, 1'b0, 0, "qB");
                expect_segment(7, 1'b1, 0, "qC");
                expect_segment(2, 1'b0, 0, "qD");
                expect_segment(4, 1'b1, 0, "qE");
            end
        join
        repeat (4) begin
            @(posedge clk); #1;
            check("q drained active", 32'(active), 32'd0);
        end
        check("q seg_done pulses", 32'(n_seg - seg_base), 32'd5);
`else
        // Without a queue the controller refuses commands while busy.
        send(3, 1'b1, 0, "nq A");
        cmd_mod    = WIDTH'(5);
        cmd_updown = 1'b0;
        cmd_rep    = '0;
        cmd_valid  = 1'b1;
        #1 check("nq busy ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        expect_segment(3, 1'b1, 0, "nq A");
        check("nq idle ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        check("nq idle active", 32'(active), 32'd0);
        check("nq idle count", 32'(count), 32'd2);
`endif

        // abort in the 3rd RUN cycle
        seg_base = n_seg;
        send(7, 1'b1, 0, "ab A");
        @(posedge clk); #1;
        check("ab run0 count", 32'(count), 32'd0);
`ifdef MODCTRL_QUEUE_EN
        send(4, 1'b0, 0, "ab B");
`else
        @(posedge clk); #1;
`endif
        check("ab run1 count", 32'(count), 32'd1);
`ifdef MODCTRL_QUEUE_EN
        send(3, 1'b1, 1, "ab C");
`else
        @(posedge clk); #1;
`endif
        check("ab run2 count", 32'(count), 32'd2);
        check("ab run2 active", 32'(active), 32'd1);
        abort      = 1'b1;
        cmd_mod    = WIDTH'(6);
        cmd_updown = 1'b1;
        cmd_rep    = '0;
        cmd_valid  = 1'b1;
        #1 check("ab ready low", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        abort     = 1'b0;
        cmd_valid = 1'b0;
        check("ab active", 32'(active), 32'd0);
        check("ab count frozen", 32'(count), 32'd2);
        check("ab seg_done", 32'(seg_done), 32'd0);
        check("ab cmd_err", 32'(cmd_err), 32'd0);
        #1 check("ab ready idle", 32'(cmd_ready), 32'd1);
        repeat (5) begin
            @(posedge clk); #1;
            check("ab stays idle", 32'(active), 32'd0);
            check("ab count held", 32'(count), 32'd2);
        end
        check("ab no seg_done", 32'(n_seg - seg_base), 32'd0);

        // asynchronous reset mid-RUN
        send(7, 1'b1, 0, "rs A");
        @(posedge clk); #1;
        check("rs run0 count", 32'(count), 32'd0);
        @(posedge clk); #1;
        check("rs run1 count", 32'(count), 32'd1);
        #3 rst = 1'b1;
        #1;
        check("rs async count", 32'(count), 32'd0);
        check("rs async active", 32'(active), 32'd0);
        check("rs async ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        check("rs held count", 32'(count), 32'd0);
        check("rs held active", 32'(active), 32'd0);
        rst = 1'b0;
        #1 check("rs release ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        send(2, 1'b0, 2, "rs B");
        expect_segment(2, 1'b0, 2, "rs B");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
